// File: rtl/spi_flash_read_master.sv
// SPI NOR READ (0x03) initiator, mode 0, single-bit I/O.
// Sends command plus 24-bit address once, then streams len bytes out.
module spi_flash_read_master #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             flash_csb,
  output logic             flash_clk,
  output logic             flash_io0,
  input  logic             flash_io1
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    GAP
  } state_t;

  localparam logic [7:0] READ_CMD = 8'h03;
  localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
  localparam logic [8:0] GAP_M1   = 9'(2 * CLK_DIV - 1);

  state_t r_state;
  state_t w_next;

  logic [7:0]       r_div;
  logic             r_clk;
  logic             r_csb;
  logic             r_io0;
  logic [30:0]      r_out;
  logic [6:0]       r_in;
  logic [4:0]       r_bits;
  logic [LEN_W-1:0] r_rem;
  logic             r_last;
  logic [8:0]       r_gap;
  logic [7:0]       r_rd_data;
  logic             r_rd_valid;
  logic             r_done0;

  logic w_active;
  logic w_tick;
  logic w_rise;
  logic w_fall;
  logic w_stop;
  logic w_byte;
  logic w_gap_end;
  logic w_accept;

  assign w_active  = (r_state == CMD) || (r_state == ADDR)
                  || (r_state == DATA);
  assign w_tick    = w_active && (r_div == DIV_M1);
  // once the last byte is in, the next would-be rising edge ends the burst
  assign w_rise    = w_tick && !r_clk && !r_last;
  assign w_stop    = w_tick && !r_clk && r_last;
  assign w_fall    = w_tick && r_clk;
  assign w_byte    = w_rise && (r_state == DATA)
                  && (r_bits[2:0] == 3'd7);
  assign w_gap_end = (r_state == GAP) && (r_gap == GAP_M1);
  assign w_accept  = (r_state == IDLE) && start
                  && (len != '0);

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = CMD;
      CMD:  if (w_rise && r_bits == 5'd7) w_next = ADDR;
      ADDR: if (w_rise && r_bits == 5'd31) w_next = DATA;
      DATA: if (w_stop) w_next = GAP;
      GAP:  if (w_gap_end) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div      <= '0;
      r_clk      <= 1'b0;
      r_csb      <= 1'b1;
      r_io0      <= 1'b0;
      r_out      <= '0;
      r_in       <= '0;
      r_bits     <= '0;
      r_rem      <= '0;
      r_last     <= 1'b0;
      r_gap      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done0    <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done0    <= 1'b0;
      if (r_state == IDLE && start) begin
        if (len != '0) begin
          r_io0  <= READ_CMD[7];
          r_out  <= {READ_CMD[6:0], addr};
          r_csb  <= 1'b0;
          r_clk  <= 1'b0;
          r_div  <= '0;
          r_bits <= '0;
          r_rem  <= len;
          r_last <= 1'b0;
        end else begin
          r_done0 <= 1'b1;
        end
      end
      if (w_active)
        r_div <= w_tick ? '0 : r_div + 8'd1;
      if (w_rise) begin
        r_clk  <= 1'b1;
        r_in   <= {r_in[5:0], flash_io1};
        r_bits <= r_bits + 5'd1;
      end
      if (w_byte) begin
        r_rd_data  <= {r_in, flash_io1};
        r_rd_valid <= 1'b1;
        r_rem      <= r_rem - LEN_W'(1);
        if (r_rem == LEN_W'(1)) r_last <= 1'b1;
      end
      // zeros shift in behind the address, so io0 idles low in DATA
      if (w_fall) begin
        r_clk <= 1'b0;
        r_io0 <= r_out[30];
        r_out <= {r_out[29:0], 1'b0};
      end
      if (w_stop) begin
        r_csb <= 1'b1;
        r_gap <= '0;
      end
      if (r_state == GAP)
        r_gap <= r_gap + 9'd1;
    end
  end

  assign busy      = (r_state != IDLE) && !w_gap_end;
  assign done      = w_gap_end || r_done0;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign flash_csb = r_csb;
  assign flash_clk = r_clk;
  assign flash_io0 = r_io0;

endmodule
